// File: rtl/spi_slave_protocol_monitor.sv
// SPI slave protocol monitor: passive checker for frame timing,
// receive data and read-back MISO against a shadow RAM.
module spi_slave_protocol_monitor #(
  parameter int ADDR_W  = 8,
  parameter int RXV_LAT = 1,
  parameter int CNT_W   = 16,
  parameter bit MEM_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic              MISO,
  input  logic              rx_valid,
  input  logic [ADDR_W+1:0] rx_data,
  output logic [5:0]        err_pulse,
  output logic [5:0]        err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  frame_count,
  output logic [2:0]        mon_state
);
  localparam int FW = ADDR_W + 2;
  localparam int CW = $clog2(FW);
  localparam int LW = (RXV_LAT < 2) ? 1 : $clog2(RXV_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [LW-1:0]     wcnt, wcnt_n;
  logic [FW-1:0]     shreg, shreg_n;
  logic              cmd_bit, cmd_n;
  logic              post_rst;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [ADDR_W-1:0] rd_sh;
  logic              rd_chk;
  logic [5:0]        err;
  logic              fc_inc, upd, load_rd, abort;
  logic [FW-1:0]     frame_in;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] payload;
  logic [ADDR_W-1:0] rd_word;
  logic              rd_ok;
  logic              wr_en;

  assign frame_in  = {shreg[FW-2:0], MOSI};
  assign opcode    = shreg[FW-1:FW-2];
  assign payload   = shreg[ADDR_W-1:0];
  assign wr_en     = upd && (opcode == 2'b01);
  assign mon_state = state;

  // Shadow RAM: only entries written by a clean write-data frame are trusted
  if (MEM_EN) begin : g_mem
    logic [ADDR_W-1:0]    mem [2**ADDR_W];
    logic [2**ADDR_W-1:0] vld;

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= payload;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld <= '0;
      else if (wr_en) vld[wr_addr] <= 1'b1;
    end

    assign rd_word = mem[rd_addr];
    assign rd_ok   = vld[rd_addr];
  end else begin : g_nomem
    assign rd_word = '0;
    assign rd_ok   = 1'b0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    shreg_n = shreg;
    cmd_n   = cmd_bit;
    err     = '0;
    fc_inc  = 1'b0;
    upd     = 1'b0;
    load_rd = 1'b0;
    abort   = SS_n &&
      (state inside {S_CMD, S_SHIFT, S_WAIT, S_READ});
    if (post_rst && (MISO || rx_valid || |rx_data))
      err[0] = 1'b1;
    if (MISO && state != S_READ)
      err[4] = 1'b1;
    if (rx_valid && state != S_WAIT)
      err[2] = 1'b1;
    if (abort) begin
      err[5]  = 1'b1;
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!SS_n) begin
            state_n = S_CMD;
            cmd_n   = MOSI;
          end
        end
        S_CMD: begin
          state_n = S_SHIFT;
          cnt_n   = '0;
        end
        S_SHIFT: begin
          shreg_n = frame_in;
          if (cnt == CW'(FW - 1)) begin
            state_n = S_WAIT;
            wcnt_n  = LW'(1);
            if (cmd_bit != frame_in[FW-1])
              err[1] = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (wcnt == LW'(RXV_LAT)) begin
            fc_inc = 1'b1;
            if (!rx_valid)
              err[2] = 1'b1;
            else if (rx_data != shreg)
              err[3] = 1'b1;
            else
              upd = 1'b1;
            load_rd = 1'b1;
            cnt_n   = '0;
            state_n = (opcode == 2'b11) ? S_READ : S_DONE;
          end else begin
            if (rx_valid)
              err[2] = 1'b1;
            wcnt_n = wcnt + 1'b1;
          end
        end
        S_READ: begin
          if (rd_chk && MISO != rd_sh[ADDR_W-1])
            err[4] = 1'b1;
          if (cnt == CW'(ADDR_W - 1))
            state_n = S_DONE;
          else
            cnt_n = cnt + 1'b1;
        end
        S_DONE: begin
          if (SS_n) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      shreg       <= '0;
      cmd_bit     <= 1'b0;
      post_rst    <= 1'b1;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_sh       <= '0;
      rd_chk      <= 1'b0;
      err_pulse   <= '0;
      err_sticky  <= '0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wcnt       <= wcnt_n;
      shreg      <= shreg_n;
      cmd_bit    <= cmd_n;
      post_rst   <= 1'b0;
      err_pulse  <= err;
      err_sticky <= err_sticky | err;
      if (|err && err_count != '1)
        err_count <= err_count + 1'b1;
      if (fc_inc && frame_count != '1)
        frame_count <= frame_count + 1'b1;
      if (upd && opcode == 2'b00)
        wr_addr <= payload;
      if (upd && opcode == 2'b10)
        rd_addr <= payload;
      if (load_rd) begin
        rd_sh  <= rd_word;
        rd_chk <= rd_ok;
      end else if (state == S_READ) begin
        rd_sh <= rd_sh << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_protocol_monitor.sv
// Bench for spi_slave_protocol_monitor: frame-level stimulus checked
// against a transaction model with a shadow memory array.
module tb_spi_slave_protocol_monitor;
  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic [5:0] err_pulse, err_sticky;
  logic [15:0] err_count, frame_count;
  logic [2:0] mon_state;
  logic [5:0] sat_pulse, sat_sticky;
  logic [1:0] sat_ecnt, sat_fcnt;
  logic [2:0] sat_state;

  int checks = 0;
  int failures = 0;
  int ecnt, fc;
  logic [5:0] sticky;
  bit [7:0] mem [256];
  bit vld [256];
  bit [7:0] wr_a, rd_a;

  spi_slave_protocol_monitor dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .frame_count(frame_count),
    .mon_state(mon_state)
  );

  spi_slave_protocol_monitor #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .rx_valid(rx_valid), .rx_data(rx_data),
    .err_pulse(sat_pulse), .err_sticky(sat_sticky),
    .err_count(sat_ecnt), .frame_count(sat_fcnt),
    .mon_state(sat_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    ecnt = 0;
    fc = 0;
    sticky = '0;
    wr_a = '0;
    rd_a = '0;
    for (int i = 0; i < 256; i++) vld[i] = 1'b0;
  endfunction

  function automatic void apply(bit [1:0] op, bit [7:0] p);
    case (op)
      2'b00: wr_a = p;
      2'b01: begin mem[wr_a] = p; vld[wr_a] = 1'b1; end
      2'b10: rd_a = p;
      default: ;
    endcase
  endfunction

  task automatic tick(input logic [5:0] e);
    @(posedge clk);
    #1;
    check("err_pulse", {26'd0, err_pulse}, {26'd0, e});
    if (e != 0) ecnt++;
    sticky |= e;
  endtask

  task automatic check_cnt();
    check("err_count", {16'd0, err_count}, 32'(ecnt));
    check("frame_count", {16'd0, frame_count}, 32'(fc));
    check("err_sticky", {26'd0, err_sticky}, {26'd0, sticky});
    check("sat_err_count", {30'd0, sat_ecnt},
          32'(ecnt > 3 ? 3 : ecnt));
    check("sat_frame_count", {30'd0, sat_fcnt},
          32'(fc > 3 ? 3 : fc));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"}, {26'd0, err_pulse}, 0);
    check({tag, "_sticky"}, {26'd0, err_sticky}, 0);
    check({tag, "_ecnt"}, {16'd0, err_count}, 0);
    check({tag, "_fcnt"}, {16'd0, frame_count}, 0);
    check({tag, "_state"}, {29'd0, mon_state}, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; SS_n = 1; MOSI = 0; MISO = 0;
    rx_valid = 0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst");
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  // One complete frame; rxv_at counts edges after the last frame bit
  task automatic frame(input bit cmd, input bit [1:0] op,
                       input bit [7:0] pay, input int rxv_at,
                       input bit bad, input bit [7:0] mw);
    logic [9:0] f, fs;
    logic [5:0] e;
    bit [7:0] mv, rw;
    bit chk_rd;
    int n;
    f = {op, pay};
    fs = f;
    SS_n = 0; MOSI = cmd; tick(0);
    MOSI = 1'($urandom_range(1)); tick(0);
    for (int i = 0; i < 10; i++) begin
      MOSI = fs[9];
      e = (i == 9 && cmd != op[1]) ? 6'b000010 : 6'b000000;
      tick(e);
      fs = fs << 1;
    end
    MOSI = 0;
    chk_rd = vld[rd_a];
    rw = mem[rd_a];
    mv = mw;
    n = (op == 2'b11) ? 9 : 1;
    if (rxv_at > n) n = rxv_at;
    for (int t = 1; t <= n; t++) begin
      e = '0;
      rx_valid = (t == rxv_at);
      rx_data = rx_valid ? (bad ? f ^ 10'h001 : f) : '0;
      if (rx_valid && t != 1) e[2] = 1'b1;
      if (t == 1) begin
        fc++;
        if (!rx_valid) e[2] = 1'b1;
        else if (bad) e[3] = 1'b1;
        else apply(op, pay);
      end
      if (op == 2'b11 && t >= 2 && t <= 9) begin
        MISO = mv[7];
        if (chk_rd && mv[7] != rw[7]) e[4] = 1'b1;
        mv = mv << 1;
        rw = rw << 1;
      end else begin
        MISO = 1'b0;
      end
      tick(e);
    end
    rx_valid = 0; rx_data = '0; MISO = 0;
    SS_n = 1; tick(0);
    repeat ($urandom_range(1)) tick(0);
  endtask

  task automatic abort_frame(input bit [1:0] op, input bit [7:0] pay,
                             input int nb);
    logic [9:0] fs;
    fs = {op, pay};
    SS_n = 0; MOSI = op[1]; tick(0);
    MOSI = 0; tick(0);
    for (int i = 0; i < nb; i++) begin
      MOSI = fs[9];
      tick(0);
      fs = fs << 1;
    end
    SS_n = 1; MOSI = 0; tick(6'b100000);
  endtask

  initial begin
    bit [1:0] op;
    bit [7:0] pay, mw;
    int r;
    clk = 0;
    do_reset();
    rx_valid = 1; tick(6'b000101);
    rx_valid = 0; tick(0);
    check_cnt();

    do_reset();
    tick(0);
    check_cnt();

    frame(0, 2'b00, 8'h2A, 1, 0, 8'h00);
    frame(0, 2'b01, 8'h5C, 1, 0, 8'h00);
    check_cnt();
    frame(1, 2'b10, 8'h2A, 1, 0, 8'h00);
    frame(1, 2'b11, 8'h00, 1, 0, 8'h5C);
    check_cnt();
    frame(1, 2'b11, 8'h00, 1, 0, 8'h5D);
    check_cnt();
    frame(0, 2'b00, 8'h11, 3, 0, 8'h00);
    check_cnt();

    frame(0, 2'b00, 8'h77, 1, 0, 8'h00);
    abort_frame(2'b01, 8'h99, 4);
    check("abort_state", {29'd0, mon_state}, 0);
    frame(1, 2'b10, 8'h77, 1, 0, 8'h00);
    frame(1, 2'b11, 8'h00, 1, 0, 8'hFF);
    check_cnt();

    frame(1, 2'b00, 8'h33, 1, 0, 8'h00);
    frame(0, 2'b01, 8'h44, 1, 1, 8'h00);
    SS_n = 1; MISO = 1; tick(6'b010000);
    MISO = 0;
    check_cnt();

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(9);
      op = 2'($urandom_range(3));
      pay = (op == 2'b01) ? 8'($urandom) : 8'($urandom_range(7));
      if (r == 0) begin
        abort_frame(op, pay, $urandom_range(9));
      end else begin
        if (r == 4) begin
          SS_n = 1; MISO = 1; tick(6'b010000);
          MISO = 0;
        end
        mw = $urandom_range(1) ? mem[rd_a] : 8'($urandom);
        frame((r == 1) ? ~op[1] : op[1], op, pay,
              (r == 3) ? 2 : 1, r == 2, mw);
      end
    end
    check_cnt();

    SS_n = 0; MOSI = 0; tick(0); tick(0);
    MOSI = 1; tick(0); tick(0);
    #2 rst_n = 0;
    #1 check_zero("midrst");
    SS_n = 1; MOSI = 0;
    model_clear();
    @(negedge clk);
    rst_n = 1;
    tick(0);
    check_cnt();
    frame(1, 2'b10, 8'h2A, 1, 0, 8'h00);
    frame(1, 2'b11, 8'h00, 1, 0, 8'hA5);
    check_cnt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
